// File: rtl/mem_arb_if.sv
// mem_arb_if: requester and memory-side bundle of mem_arb.
// slave is the arbiter side; master is requesters plus memory.
interface mem_arb_if #(
  parameter int SIZE = 16
);
  logic            f_req;
  logic [SIZE-1:0] f_addr;
  logic            f_ack;
  logic [SIZE-1:0] f_rdata;
  logic            d_req;
  logic            d_we;
  logic            d_bw;
  logic            d_lock;
  logic [SIZE-1:0] d_addr;
  logic [SIZE-1:0] d_wdata;
  logic            d_ack;
  logic [SIZE-1:0] d_rdata;
  logic            x_req;
  logic            x_we;
  logic [SIZE-1:0] x_addr;
  logic [SIZE-1:0] x_wdata;
  logic            x_ack;
  logic [SIZE-1:0] x_rdata;
  logic [SIZE-1:0] MAB_in;
  logic [SIZE-1:0] MDB_in;
  logic            MW;
  logic            BW;
  logic [SIZE-1:0] MDB_out;
  logic            busy;
  logic [1:0]      owner;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_bw, d_lock,
    input  d_addr, d_wdata,
    input  x_req, x_we, x_addr, x_wdata,
    input  MDB_out,
    output f_ack, f_rdata,
    output d_ack, d_rdata,
    output x_ack, x_rdata,
    output MAB_in, MDB_in, MW, BW,
    output busy, owner
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_bw, d_lock,
    output d_addr, d_wdata,
    output x_req, x_we, x_addr, x_wdata,
    output MDB_out,
    input  f_ack, f_rdata,
    input  d_ack, d_rdata,
    input  x_ack, x_rdata,
    input  MAB_in, MDB_in, MW, BW,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: F/D(/X) arbiter and ADDR/DATA sequencer for mem_space.
// Define MEM_ARB_DMA_EN to enable the X (DMA/debug) port.
module mem_arb #(
  parameter int SIZE       = 16,
  parameter int STARVE_MAX = 8
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  localparam logic [1:0] OWN_N = 2'd0;
  localparam logic [1:0] OWN_F = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;
  localparam logic [1:0] OWN_X = 2'd3;
  localparam logic [3:0] SMAX  = 4'(STARVE_MAX);

  state_e          state_q, state_d;
  logic [1:0]      own_q, own_d, win;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            bw_q, bw_d;
  logic            lock_q, lock_d;
  logic            f_ack_q, f_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [SIZE-1:0] f_rdata_q, f_rdata_d;
  logic [SIZE-1:0] d_rdata_q, d_rdata_d;
  logic            excl, arb_en;
  logic            f_c, d_c, x_c;
  logic            x_live, starve;

`ifdef MEM_ARB_DMA_EN
  logic            x_ack_q, x_ack_d;
  logic [SIZE-1:0] x_rdata_q, x_rdata_d;
  logic [3:0]      x_wait_q, x_wait_d;

  assign x_live = bus.x_req;
  assign starve = x_c && (x_wait_q == SMAX);
`else
  logic unused_x;

  assign unused_x = ^{bus.x_req, bus.x_we,
                      bus.x_addr, bus.x_wdata,
                      SMAX};
  assign x_live = 1'b0;
  assign starve = 1'b0;
`endif

  // The owner's req is still up at its own DATA edge
  assign excl   = (state_q == DATA);
  assign arb_en = excl || (state_q == IDLE &&
                  (bus.f_req || bus.d_req || x_live));
  assign f_c = bus.f_req && !lock_q &&
               !(excl && own_q == OWN_F);
  assign d_c = bus.d_req &&
               !(excl && own_q == OWN_D && !lock_q);
  assign x_c = x_live && !(excl && own_q == OWN_X);

  always_comb begin
    win = OWN_N;
    if (lock_q) begin
      if (d_c) win = OWN_D;
    end else if (starve) begin
      win = OWN_X;
    end else if (d_c) begin
      win = OWN_D;
    end else if (f_c) begin
      win = OWN_F;
    end else if (x_c) begin
      win = OWN_X;
    end
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    bw_d      = bw_q;
    lock_d    = lock_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      ADDR: state_d = DATA;
      DATA: begin
        unique case (own_q)
          OWN_F: begin
            f_ack_d   = 1'b1;
            f_rdata_d = bus.MDB_out;
          end
          OWN_D: begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.MDB_out;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (arb_en) begin
      state_d = (win == OWN_N) ? IDLE : ADDR;
      own_d   = win;
      lock_d  = bus.d_lock &&
                (lock_q || win == OWN_D);
      unique case (win)
        OWN_F: begin
          addr_d  = bus.f_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          bw_d    = 1'b0;
        end
        OWN_D: begin
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          we_d    = bus.d_we;
          bw_d    = bus.d_bw;
        end
`ifdef MEM_ARB_DMA_EN
        OWN_X: begin
          addr_d  = bus.x_addr;
          wdata_d = bus.x_wdata;
          we_d    = bus.x_we;
          bw_d    = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      own_q     <= OWN_N;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      bw_q      <= 1'b0;
      lock_q    <= 1'b0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      bw_q      <= bw_d;
      lock_q    <= lock_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_DMA_EN
  always_comb begin
    x_wait_d  = x_wait_q;
    x_ack_d   = excl && own_q == OWN_X;
    x_rdata_d = x_ack_d ? bus.MDB_out : x_rdata_q;
    if (arb_en && win == OWN_X) begin
      x_wait_d = '0;
    end else if (arb_en && x_c &&
                 x_wait_q != SMAX) begin
      x_wait_d = x_wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_wait_q  <= '0;
      x_ack_q   <= 1'b0;
      x_rdata_q <= '0;
    end else begin
      x_wait_q  <= x_wait_d;
      x_ack_q   <= x_ack_d;
      x_rdata_q <= x_rdata_d;
    end
  end

  assign bus.x_ack   = x_ack_q;
  assign bus.x_rdata = x_rdata_q;
`else
  assign bus.x_ack   = 1'b0;
  assign bus.x_rdata = '0;
`endif

  assign bus.busy    = (state_q != IDLE);
  assign bus.owner   = own_q;
  assign bus.MAB_in  = bus.busy ? addr_q : '0;
  assign bus.MDB_in  = bus.busy ? wdata_q : '0;
  assign bus.BW      = bus.busy && bw_q;
  assign bus.MW      = (state_q == ADDR) && we_q;
  assign bus.f_ack   = f_ack_q;
  assign bus.f_rdata = f_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vectors and hand-written sequences for mem_arb.
// Memory is a 256-word model indexed by MAB_in[7:0].
module tb_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_arb_if bus ();

  mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  assign bus.MDB_out = mem[bus.MAB_in[7:0]];
  always @(posedge clk) begin
    if (bus.MW) mem[bus.MAB_in[7:0]] <= bus.MDB_in;
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic        bw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  vec_t        tv [6];
  logic [15:0] last_f = 16'h0;
  logic [15:0] last_d = 16'h0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h00] = 16'h1234;
    mem[8'h20] = 16'h0005;
    bus.f_req = 0; bus.f_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_bw = 0;
    bus.d_lock = 0; bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.x_req = 0; bus.x_we = 0;
    bus.x_addr = '0; bus.x_wdata = '0;

    tv[0] = '{1'b0, 1'b0, 1'b0, 16'h4400, 16'h0000, 16'h1234};
    tv[1] = '{1'b1, 1'b1, 1'b1, 16'h0201, 16'h00AB, 16'h00AB};
    tv[2] = '{1'b1, 1'b0, 1'b0, 16'h0201, 16'h0000, 16'h00AB};
    tv[3] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'hBEEF};
    tv[4] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tv[5] = '{1'b1, 1'b0, 1'b0, 16'h4400, 16'h0000, 16'h1234};

    // reset state
    tick(); tick();
    chk("rst busy", bus.busy, 0);
    chk("rst owner", bus.owner, 0);
    chk("rst MW", bus.MW, 0);
    chk("rst MAB", bus.MAB_in, 0);
    chk("rst acks", {bus.f_ack, bus.d_ack, bus.x_ack}, 0);
    chk("rst f_rdata", bus.f_rdata, 0);
    chk("rst d_rdata", bus.d_rdata, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("post-rst busy", bus.busy, 0);
    chk("post-rst MDB_in", bus.MDB_in, 0);

    // single accesses
    for (int i = 0; i < 6; i++) begin
      if (tv[i].is_d) begin
        bus.d_req = 1; bus.d_we = tv[i].we;
        bus.d_bw = tv[i].bw; bus.d_lock = 0;
        bus.d_addr = tv[i].addr;
        bus.d_wdata = tv[i].wdata;
      end else begin
        bus.f_req = 1; bus.f_addr = tv[i].addr;
      end
      tick();
      chk("c1 owner", bus.owner, tv[i].is_d ? 2 : 1);
      chk("c1 busy", bus.busy, 1);
      chk("c1 MAB", bus.MAB_in, tv[i].addr);
      chk("c1 MW", bus.MW, tv[i].we);
      chk("c1 BW", bus.BW, tv[i].is_d & tv[i].bw);
      chk("c1 MDB_in", bus.MDB_in,
          tv[i].is_d ? tv[i].wdata : 16'h0);
      tick();
      chk("c2 MAB", bus.MAB_in, tv[i].addr);
      chk("c2 MW", bus.MW, 0);
      chk("c2 BW", bus.BW, tv[i].is_d & tv[i].bw);
      chk("c2 ack", {bus.f_ack, bus.d_ack}, 0);
      tick();
      if (tv[i].is_d) begin
        chk("c3 d_ack", bus.d_ack, 1);
        chk("c3 d_rdata", bus.d_rdata, tv[i].rdata);
        chk("c3 f_rdata hold", bus.f_rdata, last_f);
        last_d = tv[i].rdata;
        bus.d_req = 0;
      end else begin
        chk("c3 f_ack", bus.f_ack, 1);
        chk("c3 f_rdata", bus.f_rdata, tv[i].rdata);
        chk("c3 d_rdata hold", bus.d_rdata, last_d);
        last_f = tv[i].rdata;
        bus.f_req = 0;
      end
      chk("c3 busy", bus.busy, 0);
    end
    bus.d_we = 0; bus.d_bw = 0;
    tick();

    // F and D on the same edge: D first
    bus.f_req = 1; bus.f_addr = 16'h4400;
    bus.d_req = 1; bus.d_addr = 16'h0010;
    tick();
    chk("fd c1 owner", bus.owner, 2);
    tick();
    tick();
    chk("fd c3 d_ack", bus.d_ack, 1);
    chk("fd c3 d_rdata", bus.d_rdata, 16'hBEEF);
    chk("fd c3 owner", bus.owner, 1);
    chk("fd c3 MAB", bus.MAB_in, 16'h4400);
    bus.d_req = 0;
    tick();
    chk("fd c4 f_ack", bus.f_ack, 0);
    tick();
    chk("fd c5 f_ack", bus.f_ack, 1);
    chk("fd c5 f_rdata", bus.f_rdata, 16'h1234);
    bus.f_req = 0;
    tick();

    // locked read-modify-write with F pending
    bus.f_req = 1; bus.f_addr = 16'h4400;
    bus.d_req = 1; bus.d_lock = 1; bus.d_we = 0;
    bus.d_addr = 16'h0020; bus.d_wdata = 16'h0;
    tick();
    chk("rmw c1 owner", bus.owner, 2);
    chk("rmw c1 MW", bus.MW, 0);
    bus.d_we = 1; bus.d_wdata = 16'h0006;
    bus.d_lock = 0;
    tick();
    chk("rmw c2 owner", bus.owner, 2);
    tick();
    chk("rmw c3 owner", bus.owner, 2);
    chk("rmw c3 d_ack", bus.d_ack, 1);
    chk("rmw c3 d_rdata", bus.d_rdata, 16'h0005);
    chk("rmw c3 MW", bus.MW, 1);
    tick();
    chk("rmw c4 owner", bus.owner, 2);
    chk("rmw c4 f_ack", bus.f_ack, 0);
    tick();
    chk("rmw c5 owner", bus.owner, 1);
    chk("rmw c5 d_ack", bus.d_ack, 1);
    chk("rmw c5 mem", mem[8'h20], 16'h0006);
    bus.d_req = 0; bus.d_we = 0;
    tick();
    tick();
    chk("rmw c7 f_ack", bus.f_ack, 1);
    bus.f_req = 0;
    tick();

`ifdef MEM_ARB_DMA_EN
    begin
      logic [1:0] exp_own [10];
      int         wait_cnt;
      exp_own = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2,
                  2'd1, 2'd2, 2'd1, 2'd3, 2'd2};
      bus.f_req = 1; bus.f_addr = 16'h4400;
      bus.d_req = 1; bus.d_addr = 16'h0010;
      bus.x_req = 1; bus.x_addr = 16'h0020;
      tick();
      for (int k = 0; k < 10; k++) begin
        chk("starve owner", bus.owner, exp_own[k]);
        chk("starve x_ack", bus.x_ack,
            (k > 0 && exp_own[k-1] == 2'd3) ? 1 : 0);
        if (exp_own[k] == 2'd3)
          chk("starve x_wait", dut.x_wait_q, 0);
        if (k > 0 && exp_own[k-1] == 2'd3) begin
          chk("starve x_rdata", bus.x_rdata, 16'h0006);
          bus.x_req = 0;
        end
        tick();
        tick();
      end
      bus.f_req = 0; bus.d_req = 0; bus.x_req = 0;
      wait_cnt = 0;
      while (bus.busy && wait_cnt < 10) begin
        tick();
        wait_cnt++;
      end
      chk("starve drain", bus.busy, 0);
      tick();
    end
`else
    // X port inert without DMA support
    bus.x_req = 1; bus.x_addr = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("x off busy", bus.busy, 0);
      chk("x off owner", bus.owner, 0);
      chk("x off x_ack", bus.x_ack, 0);
    end
    bus.x_req = 0;
    tick();
`endif

    // reset during ADDR of a write
    bus.d_req = 1; bus.d_we = 1;
    bus.d_addr = 16'h0030; bus.d_wdata = 16'h5555;
    tick();
    chk("abort c1 MW", bus.MW, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort MW", bus.MW, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort owner", bus.owner, 0);
    chk("abort acks", {bus.f_ack, bus.d_ack, bus.x_ack}, 0);
    bus.d_req = 0; bus.d_we = 0;
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort no ack", bus.d_ack, 0);
      chk("abort idle", bus.busy, 0);
    end
    chk("abort mem", mem[8'h30], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two- or three-way arbiter and access sequencer for the single-port `mem_space` memory. It sits between `mem_space` and its requesters: instruction fetch (F), instruction-decoder data accesses (D) and an optional DMA/debug port (X). It owns the `MAB_in`, `MDB_in`, `MW` and `BW` nets, sequences each access through address and data phases, and returns read data with a one-cycle acknowledge.

## Interface
- `SIZE`, 16, address/data width
- `STARVE_MAX`, 8, X-port wait count that forces an X grant (1..15)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `f_req`  in  1  fetch request, held until `f_ack`
- `f_addr`  in  16  fetch word address
- `f_ack`  out  1  one-cycle completion pulse
- `f_rdata`  out  16  fetched word, valid with `f_ack`
- `d_req`, `d_we`, `d_bw`, `d_lock`  in  1 each  data request, write, byte, lock
- `d_addr`, `d_wdata`  in  16  data address, write data
- `d_ack`  out  1  completion pulse
- `d_rdata`  out  16  read data, valid with `d_ack`
- `x_req`, `x_we`  in  1 each  DMA request and write (word only)
- `x_addr`, `x_wdata`  in  16  DMA address and write data
- `x_ack`  out  1  completion pulse
- `x_rdata`  out  16  DMA read data
- `MAB_in`  out  16  memory address bus
- `MDB_in`  out  16  memory write data
- `MW`  out  1  memory write strobe
- `BW`  out  1  byte access
- `MDB_out`  in  16  memory read data, valid in the DATA phase
- `busy`  out  1  high when state is not IDLE
- `owner`  out  2  current grant: 0 none, 1 F, 2 D, 3 X

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: arbitrate when any request is high, then latch the winner's addr, wdata, we and bw, and move to ADDR.
- ADDR: drive `MAB_in` and `MDB_in` from latched values; `MW` = latched we for this cycle only. Go to DATA.
- DATA: `MAB_in`, `MDB_in` and `BW` stay held, `MW` = 0. At the clock edge:
  - register `MDB_out` into the owner's rdata;
  - pulse the owner's ack for the next cycle;
  - re-arbitrate. If there is a winner, go to ADDR, otherwise go to IDLE.
- At the DATA-edge arbitration, the current owner is excluded because its req is still high for the transaction being acked. Exception: a lock held by D.
- Priority, highest first:
  1. Locked D.
  2. Starved X (`x_wait == STARVE_MAX`).
  3. D.
  4. F.
  5. X.
- Lock: `d_lock` is sampled at D grant and sets `lock_r`. While `lock_r` = 1, only D can be granted. F and X wait. `lock_r` clears at any arbitration point where `d_lock` = 0.
  - A locked D is not excluded at the DATA edge: a read-modify-write pair runs back-to-back.
- Starvation: `x_wait` increments at each arbitration where `x_req` = 1 and X loses. It saturates at `STARVE_MAX` and clears on an X grant. A locked D still beats a starved X.
- `BW` = latched `d_bw` for D grants; 0 for F and X.
- `rdata` registers of non-owners hold their last value.
- `MAB_in`, `MDB_in` and `BW` are 0 in IDLE.
- Requesters must keep req and fields stable until ack. Dropping req before ack is illegal: the arbiter completes the latched access anyway.

## Timing
- Reset values: every output 0, state IDLE, `lock_r` 0, `x_wait` 0, all latches 0.
- Reset mid-access: aborts immediately. No ack is issued and `MW` drops asynchronously.
- Latency: req sampled high in IDLE at edge 0 → ADDR in cycle 1 → DATA in cycle 2 → ack high in cycle 3.
- Throughput: one access per 2 cycles with back-to-back grants. The ack cycle of one access coincides with ADDR of the next.
- Simultaneous requests at one edge: a single grant by priority. Losers keep waiting; no request is lost.
- `MW` is high for exactly one cycle per write, never in DATA or IDLE.

## Configuration
- `MEM_ARB_DMA_EN` defined: X port active, `x_wait` counter present, three-way arbitration.
- Undefined: X ports remain for pinout stability, but `x_req` is ignored, `x_ack`/`x_rdata` are tied 0 and the `x_wait` logic is removed. `owner` never equals 3.

## Test plan
- Single F read: `f_req`=1, `f_addr`=0x4400, memory holds 0x1234 → `MAB_in`=0x4400 in cycles 1–2, `f_ack`=1 with `f_rdata`=0x1234 in cycle 3, `MW` never high.
- D byte write: `d_we`=1, `d_bw`=1, `d_addr`=0x0201, `d_wdata`=0x00AB → `MW`=1 in cycle 1 only, `BW`=1 in cycles 1–2, `d_ack` in cycle 3.
- F and D requested on the same edge → D is granted first (`owner`=2). F enters ADDR in the `d_ack` cycle and `f_ack` comes 2 cycles after `d_ack`.
- Locked RMW: D read with `d_lock`=1, F pending, then D write with `d_lock`=0 → both D accesses complete before F. `owner` stays 2 across 4 consecutive cycles.
- Starvation (with `MEM_ARB_DMA_EN`, `STARVE_MAX`=8): F and D continuously requesting, `x_req`=1 → X is granted on the arbitration after its 8th loss, and `x_wait` reads 0 after the grant.
- Reset asserted during the ADDR of a write → `MW`, `busy`, `owner` and all acks go to 0 immediately. After release, the state is IDLE and no ack is issued for the aborted write.
